// File: rtl/bus_demux_bridge_if.sv
// CPU-side bus of the demux bridge.
// The CPU drives a request: req, we, addr, wdata, be.
// The bridge answers with a one-cycle ready pulse, plus rdata and err.
// Modports:
//   master - the CPU side.
//   slave  - the bridge side.
interface bus_demux_bridge_if #(
    parameter int DataBit = 32
);
    logic               req;
    logic               we;
    logic [31:0]        addr;
    logic [DataBit-1:0] wdata;
    logic [3:0]         be;
    logic               ready;
    logic [DataBit-1:0] rdata;
    logic               err;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata, err
    );
endinterface

// File: rtl/bus_demux_bridge.sv
// bus_demux_bridge: routes a single outstanding CPU access to one of four devices.
//
// Address map:
//   dev0  0x0000_0000 .. 0x0000_2FFF
//   dev1  0x0000_7F00 .. 0x0000_7F0B
//   dev2  0x0000_7F10 .. 0x0000_7F1B
//   dev3  0x0000_7F20 .. 0x0000_7F3F
// Any other address returns an error response and no device is selected.
// A write with all byte enables clear also returns an error.
// A selected device that gives no acknowledge within TIMEOUT cycles
// produces an error response.
//
// Ports:
//   clk, rst_n    clock; asynchronous active-low reset
//   cpu           CPU bus (slave modport):
//                   request: req/we/addr/wdata/be
//                   response: ready/rdata/err
//   busy          high while not IDLE
//   dev_sel       one-hot device select
//   dev_we, dev_addr, dev_wdata, dev_be
//                 latched request fields, shared by all devices
//   dev_ack       per-device acknowledge
//   dev_rdata0..3 per-device read data
module bus_demux_bridge #(
    parameter int DataBit = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_demux_bridge_if.slave  cpu,
    output logic               busy,
    output logic [3:0]         dev_sel,
    output logic               dev_we,
    output logic [31:0]        dev_addr,
    output logic [DataBit-1:0] dev_wdata,
    output logic [3:0]         dev_be,
    input  logic [3:0]         dev_ack,
    input  logic [DataBit-1:0] dev_rdata0,
    input  logic [DataBit-1:0] dev_rdata1,
    input  logic [DataBit-1:0] dev_rdata2,
    input  logic [DataBit-1:0] dev_rdata3
);
    localparam int CntW = $clog2(TIMEOUT + 1);

    // Region base addresses and sizes minus one, indexed by device number.
    localparam logic [3:0][31:0] DEV_BASE = {32'h0000_7F20, 32'h0000_7F10,
                                             32'h0000_7F00, 32'h0000_0000};
    localparam logic [3:0][31:0] DEV_SPAN = {32'h0000_001F, 32'h0000_000B,
                                             32'h0000_000B, 32'h0000_2FFF};

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_reg;
    logic [CntW-1:0]    cnt_reg;
    logic [3:0]         sel_reg;
    logic               we_reg;
    logic [31:0]        addr_reg;
    logic [DataBit-1:0] wdata_reg;
    logic [3:0]         be_reg;
    logic               ready_reg;
    logic               err_reg;
    logic [DataBit-1:0] rdata_reg;

    logic [3:0]         hit;
    logic               ack_hit;
    logic               legal;
    logic [DataBit-1:0] sel_rdata;

    // The unsigned offset compare covers base <= addr <= base+span in one test.
    // Address wrap-around makes any address below the base look huge,
    // so it fails the compare.
    for (genvar gi = 0; gi < 4; gi++) begin : g_decode
        assign hit[gi] = (cpu.addr - DEV_BASE[gi]) <= DEV_SPAN[gi];
    end

    assign legal   = (|hit) && !(cpu.we && (cpu.be == 4'b0000));
    assign ack_hit = |(dev_ack & sel_reg);

    always_comb begin
        sel_rdata = '0;
        if (sel_reg[0]) sel_rdata = sel_rdata | dev_rdata0;
        if (sel_reg[1]) sel_rdata = sel_rdata | dev_rdata1;
        if (sel_reg[2]) sel_rdata = sel_rdata | dev_rdata2;
        if (sel_reg[3]) sel_rdata = sel_rdata | dev_rdata3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sel_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu.req) begin
                        we_reg    <= cpu.we;
                        addr_reg  <= cpu.addr;
                        wdata_reg <= cpu.wdata;
                        be_reg    <= cpu.be;
                        if (legal) begin
                            state_reg <= ACCESS;
                            sel_reg   <= hit;
                            cnt_reg   <= '0;
                        end else begin
                            state_reg <= RESP;
                            ready_reg <= 1'b1;
                            err_reg   <= 1'b1;
                            rdata_reg <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // The acknowledge is tested before the timeout,
                    // so an ack in the final cycle still completes cleanly.
                    if (ack_hit) begin
                        state_reg <= RESP;
                        sel_reg   <= '0;
                        ready_reg <= 1'b1;
                        err_reg   <= 1'b0;
                        rdata_reg <= we_reg ? '0 : sel_rdata;
                    end else if (cnt_reg == CntW'(TIMEOUT - 1)) begin
                        state_reg <= RESP;
                        sel_reg   <= '0;
                        ready_reg <= 1'b1;
                        err_reg   <= 1'b1;
                        rdata_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign dev_sel   = sel_reg;
    assign dev_we    = we_reg;
    assign dev_addr  = addr_reg;
    assign dev_wdata = wdata_reg;
    assign dev_be    = be_reg;
    assign cpu.ready = ready_reg;
    assign cpu.err   = err_reg;
    assign cpu.rdata = rdata_reg;
endmodule
